// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file dimensions and dump engine state encoding
package cpu_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 3;
   localparam int NUM_REGS   = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      CAP  = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } dump_state_t;

endpackage

// File: rtl/reg_dump_unit.sv
// rtl/reg_dump_unit.sv - sweeps the register file in index order and streams each value
module reg_dump_unit
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rf_read_reg,
   input  logic [DATA_WIDTH-1:0] rf_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_index,
   output logic [DATA_WIDTH-1:0] checksum
);

   dump_state_t           r_state;
   dump_state_t           w_next;
   logic [ADDR_WIDTH-1:0] r_idx;
   logic [ADDR_WIDTH-1:0] r_rf_read_reg;
   logic [ADDR_WIDTH-1:0] r_out_index;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [DATA_WIDTH-1:0] r_checksum;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_last;
   logic                  w_hs;

   assign w_last = (r_idx == ADDR_WIDTH'(NUM_REGS - 1));
   assign w_hs   = r_out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = ADDR;
         ADDR:    w_next = CAP;
         CAP:     w_next = SEND;
         SEND:    if (w_hs) w_next = w_last ? DONE : ADDR;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath registers; every output is driven straight from one of these.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= '0;
         r_rf_read_reg <= '0;
         r_out_index   <= '0;
         r_out_data    <= '0;
         r_checksum    <= '0;
         r_out_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx         <= '0;
                  r_rf_read_reg <= '0;
                  r_checksum    <= '0;
                  r_busy        <= 1'b1;
               end
            end
            CAP: begin
               r_out_data  <= rf_read_data;
               r_out_index <= r_idx;
               r_checksum  <= r_checksum ^ rf_read_data;
               r_out_valid <= 1'b1;
            end
            SEND: begin
               if (w_hs) begin
                  r_out_valid <= 1'b0;
                  if (!w_last) begin
                     r_idx         <= r_idx + ADDR_WIDTH'(1);
                     r_rf_read_reg <= r_idx + ADDR_WIDTH'(1);
                  end
               end
            end
            DONE: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign rf_read_reg = r_rf_read_reg;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_index   = r_out_index;
   assign checksum    = r_checksum;

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb/tb_reg_dump_unit.sv - self-checking bench for reg_dump_unit
module tb_reg_dump_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] rf_read_reg;
   logic [7:0] rf_read_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_index;
   logic [7:0] checksum;

   logic [7:0] rf [8];
   assign rf_read_data = rf[rf_read_reg];

   always #5 clk = ~clk;

   reg_dump_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .rf_read_reg  (rf_read_reg),
      .rf_read_data (rf_read_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_index    (out_index),
      .checksum     (checksum)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] regs;
      int          stall_idx;
      int          stall_len;
      int          wr_idx;
      logic [7:0]  wr_val;
      bit          extra_start;
      bit          rand_ready;
      bit          check_lat;
      logic [7:0]  exp_cs;
   } vec_t;

   function automatic logic [7:0] xor_model(input logic [63:0] r);
      logic [7:0] x = 8'd0;
      for (int i = 0; i < 8; i++) x ^= r[8*i +: 8];
      return x;
   endfunction

   task automatic run_dump(input vec_t v, input string tag);
      logic [7:0] exp_q[$];
      int         words = 0, dones = 0, first_cyc = -1, done_cyc = -1;
      int         stall_left;
      logic [7:0] cs_done = 8'd0, held_d = 8'd0;
      logic [2:0] held_i = 3'd0;
      bit         mid_sent = 0, done_sent = 0;

      for (int i = 0; i < 8; i++) begin
         rf[i] = v.regs[8*i +: 8];
         exp_q.push_back(v.regs[8*i +: 8]);
      end
      if (v.wr_idx >= 0) exp_q[v.wr_idx] = v.wr_val;
      stall_left = v.stall_len;

      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);

      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start = 1'b0;
         if (done) begin
            dones++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               cs_done  = checksum;
            end
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         if (out_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (v.stall_idx == int'(out_index) && stall_left > 0) begin
               if (stall_left == v.stall_len) begin
                  held_d = out_data;
                  held_i = out_index;
               end else begin
                  check({tag, "_stall_data"}, out_data, held_d);
                  check({tag, "_stall_index"}, out_index, held_i);
               end
               stall_left--;
               out_ready = 1'b0;
            end else if (v.rand_ready && $urandom_range(3) == 0) begin
               out_ready = 1'b0;
            end else begin
               out_ready = 1'b1;
               if (words < 8) begin
                  check($sformatf("%s_word%0d_index", tag, words), out_index, words);
                  check($sformatf("%s_word%0d_data", tag, words), out_data, exp_q[words]);
               end else begin
                  check({tag, "_extra_word"}, words, 7);
               end
               words++;
               // rf[wr_idx] is not yet captured; rf[0] already was, so it must not show up
               if (v.wr_idx > 0 && words == v.wr_idx) begin
                  rf[v.wr_idx] = v.wr_val;
                  rf[0] = ~rf[0];
               end
            end
            if (v.extra_start && out_index == 3'd4 && !mid_sent) begin
               start = 1'b1;
               mid_sent = 1;
            end
         end else begin
            out_ready = 1'b1;
            if (v.extra_start && words == 8 && !done_sent && done_cyc < 0) begin
               start = 1'b1;
               done_sent = 1;
            end
         end
      end
      start = 1'b0;
      out_ready = 1'b1;

      check({tag, "_word_count"}, words, 8);
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_checksum"}, cs_done, v.exp_cs);
      check({tag, "_busy_idle"}, busy, 0);
      if (v.stall_len > 0) check({tag, "_stall_consumed"}, stall_left, 0);
      if (v.check_lat) begin
         check({tag, "_first_valid_cycle"}, first_cyc, 2);
         check({tag, "_done_cycle"}, done_cyc, 25);
      end
   endtask

   localparam logic [63:0] BASIC = {8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd25, 8'd13};

   initial begin
      vec_t tbl [4];
      vec_t rv;
      int   dcnt;
      bit   reached;

      rst_n = 1'b0;
      start = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) rf[i] = 8'd0;

      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_rd_reg", rf_read_reg, 0);
      check("rst_data", out_data, 0);
      check("rst_index", out_index, 0);
      check("rst_checksum", checksum, 0);
      rst_n = 1'b1;
      @(negedge clk);

      tbl[0] = '{BASIC, -1, 0, -1, 8'd0,  0, 0, 1, 8'd43};
      tbl[1] = '{BASIC,  3, 5, -1, 8'd0,  0, 0, 0, 8'd43};
      tbl[2] = '{BASIC, -1, 0, -1, 8'd0,  1, 0, 1, 8'd43};
      tbl[3] = '{BASIC, -1, 0,  6, 8'd99, 0, 0, 1, 8'd88};
      for (int t = 0; t < 4; t++) run_dump(tbl[t], $sformatf("vec%0d", t));

      for (int k = 0; k < 6; k++) begin
         rv.regs        = {$urandom, $urandom};
         rv.stall_idx   = int'($urandom_range(7));
         rv.stall_len   = int'($urandom_range(4, 1));
         rv.wr_idx      = -1;
         rv.wr_val      = 8'd0;
         rv.extra_start = 0;
         rv.rand_ready  = 1;
         rv.check_lat   = 0;
         rv.exp_cs      = xor_model(rv.regs);
         run_dump(rv, $sformatf("rand%0d", k));
      end

      for (int i = 0; i < 8; i++) rf[i] = BASIC[8*i +: 8];
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reached = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (out_valid && out_index == 3'd5) begin
            reached = 1;
            break;
         end
      end
      check("midrst_reached_idx5", reached, 1);
      out_ready = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_data", out_data, 0);
      check("midrst_index", out_index, 0);
      check("midrst_rd_reg", rf_read_reg, 0);
      check("midrst_checksum", checksum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      dcnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      check("midrst_no_activity", dcnt, 0);
      run_dump(tbl[0], "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
